// File: rtl/state_dump_streamer_pkg.sv
// Shared definitions for the register-file / data-memory state dump streamer.
//  - default dump sizes matching the CPU build (32 GPRs, 4-byte data memory)
//  - stream tag bytes, shared with the host-side decoder and the bench
//  - FSM state encoding
package state_dump_streamer_pkg;

  localparam int GPR_SIZE      = 32;
  localparam int DATA_MEM_SIZE = 4;

  localparam logic [7:0] DUMP_TAG_GPR = 8'hA5;
  localparam logic [7:0] DUMP_TAG_DM  = 8'h5A;
  localparam logic [7:0] DUMP_TAG_END = 8'hFF;

  // Bytes per record: 2 index bytes + payload.
  localparam logic [2:0] GPR_REC_TAIL = 3'd5;  // bytes after the first one
  localparam logic [2:0] DM_REC_TAIL  = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GPR_HDR,
    S_GPR_RD,
    S_GPR_TX,
    S_DM_HDR,
    S_DM_RD,
    S_DM_WAIT,
    S_DM_TX,
    S_TRL,
    S_CHK,
    S_DONE
  } dump_state_t;

endpackage

// File: rtl/dump_tx_slice.sv
// Output stage of the dump streamer.
//  Holds the valid/ready output register and the running mod-256 checksum.
//  Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            clear the checksum (start of a new stream)
//   load           capture load_byte and raise tx_valid; the parent only
//                  asserts it when the register is empty or draining this cycle
//   load_byte      byte to present
//   tx_ready       sink ready
//   tx_valid/data  stream output, held stable until the handshake
//   accept         handshake this cycle (tx_valid && tx_ready)
//   chk            sum of every byte accepted since the last clr
module dump_tx_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       accept,
  output logic [7:0] chk
);

  logic       tx_valid_reg;
  logic [7:0] tx_data_reg;
  logic [7:0] chk_reg;

  assign accept   = tx_valid_reg && tx_ready;
  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign chk      = chk_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      chk_reg      <= 8'h00;
    end else begin
      // A load may coincide with the handshake of the previous byte,
      // giving back-to-back bytes with no bubble.
      if (load) begin
        tx_valid_reg <= 1'b1;
        tx_data_reg  <= load_byte;
      end else if (accept) begin
        tx_valid_reg <= 1'b0;
      end
      // Checksum only moves on real transfers, never on bubbles.
      if (clr) begin
        chk_reg <= 8'h00;
      end else if (accept) begin
        chk_reg <= chk_reg + tx_data_reg;
      end
    end
  end

endmodule

// File: rtl/state_dump_streamer.sv
// Walks the GPR file, then data memory, and serialises every entry as an
// indexed record on a valid/ready byte stream closed by a checksum:
//   A5, GPR_N x {idx_hi, idx_lo, d3, d2, d1, d0}, 5A,
//   DM_N x {idx_hi, idx_lo, byte}, FF, CHK
// Ports:
//  clk, rst_n       clock, asynchronous active-low reset
//  start_i          dump request, honoured only in IDLE
//  busy_o           high from start acceptance through the DONE cycle
//  done_o           one-cycle pulse after the last byte handshake
//  gpr_raddr_o/gpr_rdata_i  GPR read port (combinational read)
//  dm_raddr_o/dm_rdata_i    DM read port (data one cycle after address)
//  tx_valid_o/tx_data_o/tx_ready_i  output byte stream
module state_dump_streamer
  import state_dump_streamer_pkg::*;
#(
  parameter int GPR_N = GPR_SIZE,
  parameter int DM_N  = DATA_MEM_SIZE,
  parameter int DM_AW = (DM_N > 1) ? $clog2(DM_N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       gpr_raddr_o,
  input  logic [31:0]      gpr_rdata_i,
  output logic [DM_AW-1:0] dm_raddr_o,
  input  logic [7:0]       dm_rdata_i,
  output logic             tx_valid_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i
);

  localparam logic [15:0] GPR_LAST = 16'(GPR_N - 1);
  localparam logic [15:0] DM_LAST  = 16'(DM_N - 1);

  dump_state_t      state_reg, state_next;
  logic [15:0]      idx_reg, idx_next;
  logic [47:0]      buf_reg, buf_next;   // remaining record bytes, MSB first
  logic [2:0]       cnt_reg, cnt_next;   // bytes still waiting in buf_reg
  logic [7:0]       gpr_addr_reg;
  logic [DM_AW-1:0] dm_addr_reg;

  logic       load;
  logic [7:0] load_byte;
  logic       clr;
  logic       accept;
  logic [7:0] chk;
  logic       tx_valid;
  logic [7:0] tx_data;

  dump_tx_slice u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_byte (load_byte),
    .tx_ready  (tx_ready_i),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .accept    (accept),
    .chk       (chk)
  );

  assign tx_valid_o  = tx_valid;
  assign tx_data_o   = tx_data;
  assign gpr_raddr_o = gpr_addr_reg;
  assign dm_raddr_o  = dm_addr_reg;
  assign busy_o      = (state_reg != S_IDLE);
  assign done_o      = (state_reg == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 16'h0000;
      buf_reg      <= 48'h0;
      cnt_reg      <= 3'd0;
      gpr_addr_reg <= 8'h00;
      dm_addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      buf_reg   <= buf_next;
      cnt_reg   <= cnt_next;
      // Addresses are registered on entry to the read state, so they are
      // valid throughout *_RD and hold their value everywhere else.
      if (state_next == S_GPR_RD) begin
        gpr_addr_reg <= idx_next[7:0];
      end
      if (state_next == S_DM_RD) begin
        dm_addr_reg <= idx_next[DM_AW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    buf_next   = buf_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    load_byte  = 8'h00;
    clr        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // The header is loaded on the accepting edge so tx_valid is up
        // in the very next cycle.
        if (start_i) begin
          clr        = 1'b1;
          load       = 1'b1;
          load_byte  = DUMP_TAG_GPR;
          idx_next   = 16'h0000;
          state_next = S_GPR_HDR;
        end
      end

      S_GPR_HDR: begin
        if (accept) begin
          state_next = S_GPR_RD;
        end
      end

      S_GPR_RD: begin
        // Output register is empty here (the bubble); first record byte is
        // loaded directly, the rest are parked in the shift buffer.
        load       = 1'b1;
        load_byte  = idx_reg[15:8];
        buf_next   = {idx_reg[7:0], gpr_rdata_i, 8'h00};
        cnt_next   = GPR_REC_TAIL;
        state_next = S_GPR_TX;
      end

      S_GPR_TX: begin
        if (accept) begin
          if (cnt_reg != 3'd0) begin
            load      = 1'b1;
            load_byte = buf_reg[47:40];
            buf_next  = {buf_reg[39:0], 8'h00};
            cnt_next  = cnt_reg - 3'd1;
          end else if (idx_reg == GPR_LAST) begin
            load       = 1'b1;
            load_byte  = DUMP_TAG_DM;
            idx_next   = 16'h0000;
            state_next = S_DM_HDR;
          end else begin
            idx_next   = idx_reg + 16'd1;
            state_next = S_GPR_RD;
          end
        end
      end

      S_DM_HDR: begin
        if (accept) begin
          state_next = S_DM_RD;
        end
      end

      S_DM_RD: begin
        state_next = S_DM_WAIT;
      end

      S_DM_WAIT: begin
        load       = 1'b1;
        load_byte  = idx_reg[15:8];
        buf_next   = {idx_reg[7:0], dm_rdata_i, 32'h0};
        cnt_next   = DM_REC_TAIL;
        state_next = S_DM_TX;
      end

      S_DM_TX: begin
        if (accept) begin
          if (cnt_reg != 3'd0) begin
            load      = 1'b1;
            load_byte = buf_reg[47:40];
            buf_next  = {buf_reg[39:0], 8'h00};
            cnt_next  = cnt_reg - 3'd1;
          end else if (idx_reg == DM_LAST) begin
            load       = 1'b1;
            load_byte  = DUMP_TAG_END;
            state_next = S_TRL;
          end else begin
            idx_next   = idx_reg + 16'd1;
            state_next = S_DM_RD;
          end
        end
      end

      S_TRL: begin
        // The accumulator only absorbs the trailer on this same edge, so
        // fold it in here to emit the checksum without a bubble.
        if (accept) begin
          load       = 1'b1;
          load_byte  = chk + tx_data;
          state_next = S_CHK;
        end
      end

      S_CHK: begin
        if (accept) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_state_dump_streamer.sv
module tb_state_dump_streamer;
  import state_dump_streamer_pkg::*;

  localparam int GPR_N = 32;
  localparam int DM_N  = 4;
  localparam int DM_AW = 2;
  localparam int TOTAL = 4 + 6 * GPR_N + 3 * DM_N;  // 208

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [7:0]       gpr_raddr;
  logic [31:0]      gpr_rdata;
  logic [DM_AW-1:0] dm_raddr;
  logic [7:0]       dm_rdata = 8'h00;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready = 1'b1;

  logic [31:0] gpr_mem [GPR_N];
  logic [7:0]  dm_mem  [DM_N];

  int         compared   = 0;
  int         mismatched = 0;
  int         rx_count   = 0;
  int         done_count = 0;
  bit         rand_ready = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] last_byte  = 8'h00;
  logic [7:0] exp_q [$];

  state_dump_streamer #(.GPR_N(GPR_N), .DM_N(DM_N), .DM_AW(DM_AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .gpr_raddr_o (gpr_raddr),
    .gpr_rdata_i (gpr_rdata),
    .dm_raddr_o  (dm_raddr),
    .dm_rdata_i  (dm_rdata),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready)
  );

  always #5 clk = ~clk;

  // Register file: combinational read. Data memory: synchronous read.
  assign gpr_rdata = gpr_mem[gpr_raddr[4:0]];
  always @(posedge clk) dm_rdata <= dm_mem[dm_raddr];

  // Sink readiness changes just after the active edge.
  always @(posedge clk) begin
    #1 tx_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        cmp("stall_valid_held", {31'd0, tx_valid}, 32'd1);
        cmp("stall_data_held", {24'd0, tx_data}, {24'd0, stall_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("rx byte %0d: data=%02h expected=%02h", rx_count, tx_data, e);
          cmp("stream_byte", {24'd0, tx_data}, {24'd0, e});
        end
        rx_count++;
        last_byte = tx_data;
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (done) done_count++;
    end
  end

  // Reference stream built from the bench's own copy of RF/DM contents.
  task automatic push_stream();
    logic [7:0] c;
    logic [7:0] b [$];
    c = 8'h00;
    b.push_back(DUMP_TAG_GPR);
    for (int i = 0; i < GPR_N; i++) begin
      b.push_back(8'h00); b.push_back(8'(i));
      b.push_back(gpr_mem[i][31:24]); b.push_back(gpr_mem[i][23:16]);
      b.push_back(gpr_mem[i][15:8]);  b.push_back(gpr_mem[i][7:0]);
    end
    b.push_back(DUMP_TAG_DM);
    for (int i = 0; i < DM_N; i++) begin
      b.push_back(8'h00); b.push_back(8'(i)); b.push_back(dm_mem[i]);
    end
    b.push_back(DUMP_TAG_END);
    foreach (b[k]) begin
      c = c + b[k];
      exp_q.push_back(b[k]);
    end
    exp_q.push_back(c);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int target, input int budget);
    int n = 0;
    while (rx_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    cmp(name, {31'd0, rx_count >= target}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_count;
    int n  = 0;
    while (done_count == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    cmp(name, {31'd0, done_count != d0}, 32'd1);
  endtask

  // Full dump: first-byte latency, byte count, single done pulse, idle after.
  task automatic run_stream(input string name);
    int rx0;
    int d0;
    exp_q.delete();
    push_stream();
    rx0 = rx_count;
    d0  = done_count;
    pulse_start();
    cmp({name, "_valid_next_cycle"}, {31'd0, tx_valid}, 32'd1);
    cmp({name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done({name, "_done_timeout"}, 3000);
    repeat (4) @(negedge clk);
    cmp({name, "_byte_count"}, rx_count - rx0, TOTAL);
    cmp({name, "_done_pulses"}, done_count - d0, 32'd1);
    cmp({name, "_queue_empty"}, exp_q.size(), 32'd0);
    cmp({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < GPR_N; i++) gpr_mem[i] = 32'h0101_0101 * i;
    gpr_mem[0] = 32'h0000_0000;
    gpr_mem[1] = 32'h1234_5678;
    dm_mem[0] = 8'h11; dm_mem[1] = 8'h22; dm_mem[2] = 8'h33; dm_mem[3] = 8'h44;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    load_pattern();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cmp("idle_valid", {31'd0, tx_valid}, 32'd0);
      cmp("idle_busy", {31'd0, busy}, 32'd0);
      cmp("idle_done", {31'd0, done}, 32'd0);
    end
    cmp("reset_gpr_raddr", {24'd0, gpr_raddr}, 32'd0);
    cmp("reset_dm_raddr", {30'd0, dm_raddr}, 32'd0);

    // 2: patterned contents, sink always ready
    run_stream("s2");

    // 3: all zero; checksum hand-computed as F4
    for (int i = 0; i < GPR_N; i++) gpr_mem[i] = 32'h0;
    for (int i = 0; i < DM_N; i++) dm_mem[i] = 8'h00;
    run_stream("s3");
    cmp("s3_chk_f4", {24'd0, last_byte}, 32'h0000_00F4);

    // 4: same data as scenario 2, sink ready ~30% of cycles
    load_pattern();
    rand_ready = 1'b1;
    run_stream("s4");
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // 5: start pulses mid-dump and during done are ignored
    begin
      int rx0;
      int n;
      exp_q.delete();
      push_stream();
      rx0 = rx_count;
      pulse_start();
      wait_rx("s5_reach_30", rx0 + 30, 500);
      pulse_start();
      cmp("s5_busy_mid", {31'd0, busy}, 32'd1);
      n = 0;
      while (!done && n < 2000) begin
        @(negedge clk);
        n++;
      end
      cmp("s5_done_seen", {31'd0, done}, 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      cmp("s5_busy_after_done_start", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge clk);
      cmp("s5_no_second_stream", {31'd0, tx_valid}, 32'd0);
      cmp("s5_busy_idle", {31'd0, busy}, 32'd0);
      cmp("s5_byte_count", rx_count - rx0, TOTAL);
      cmp("s5_queue_empty", exp_q.size(), 32'd0);
    end

    // 6: reset after byte 50, then a clean full restart
    begin
      int rx0;
      exp_q.delete();
      push_stream();
      rx0 = rx_count;
      pulse_start();
      wait_rx("s6_reach_50", rx0 + 50, 500);
      rst_n = 1'b0;
      #1;
      cmp("s6_rst_valid", {31'd0, tx_valid}, 32'd0);
      cmp("s6_rst_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_stream("s6");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
